// File: rtl/yousei_pkg.sv
// yousei_pkg: shared opcodes, fetch state encoding and word width for the Yousei core
package yousei_pkg;
    localparam int WORD = 32;
    localparam logic [5:0] OP_JUMP = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b001010;
    localparam logic [5:0] OP_JR   = 6'b010011;
    localparam logic [5:0] OP_NOP  = 6'b001100;
    typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_FAULT} estado_t;
endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: fetch unit bus between the core control, instruction memory and debug
interface unidade_busca_if;
    import yousei_pkg::*;
    logic [WORD-1:0] Instrucao;
    logic            Stall;
    logic            BranchTaken;
    logic [15:0]     BranchAlvo;
    logic            JrValido;
    logic [WORD-1:0] JrAlvo;
    logic [WORD-1:0] Endereco;
    logic [WORD-1:0] PCMais1;
    logic            Halted;
    logic            Fault;
    logic [WORD-1:0] InstrCount;
    modport master (
        input  Instrucao, Stall, BranchTaken, BranchAlvo, JrValido, JrAlvo,
        output Endereco, PCMais1, Halted, Fault, InstrCount
    );
    modport slave (
        output Instrucao, Stall, BranchTaken, BranchAlvo, JrValido, JrAlvo,
        input  Endereco, PCMais1, Halted, Fault, InstrCount
    );
endinterface

// File: rtl/unidade_busca_selecao_prox_pc.sv
// selecao_prox_pc: next-PC mux with halt (self-jump) and out-of-range detection
module selecao_prox_pc
    import yousei_pkg::*;
#(
    parameter int MEM_DEPTH = 53
) (
    input  logic [WORD-1:0] endereco,
    input  logic [WORD-1:0] instrucao,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_alvo,
    input  logic            jr_valido,
    input  logic [WORD-1:0] jr_alvo,
    output logic [WORD-1:0] prox_pc,
    output logic            halt,
    output logic            fora
);
    localparam logic [WORD-1:0] LIMITE = WORD'(MEM_DEPTH);
    logic            salto;
    logic [WORD-1:0] alvo_salto;
    always_comb begin
        salto      = instrucao[31:26] == OP_JUMP;
        alvo_salto = {6'b0, instrucao[25:0]};
        prox_pc    = stall        ? endereco :
                     jr_valido    ? jr_alvo :
                     branch_taken ? {16'b0, branch_alvo} :
                     salto        ? alvo_salto : endereco + 32'd1;
        // a jump onto itself only halts when the jump is the selected source
        halt       = !stall && !jr_valido && !branch_taken && salto && alvo_salto == endereco;
        fora       = !stall && !halt && prox_pc >= LIMITE;
    end
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit holding PC, run/halt/fault state and retired count
module unidade_busca
    import yousei_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_DEPTH = 53
) (
    input logic              Clock,
    input logic              Reset,
    unidade_busca_if.master  bus
);
    estado_t         estado, prox_estado;
    logic [WORD-1:0] pc, prox_pc, sel_pc, cnt, prox_cnt;
    logic            halt, fora;
    selecao_prox_pc #(.MEM_DEPTH(MEM_DEPTH)) u_sel (
        .endereco    (pc),
        .instrucao   (bus.Instrucao),
        .stall       (bus.Stall),
        .branch_taken(bus.BranchTaken),
        .branch_alvo (bus.BranchAlvo),
        .jr_valido   (bus.JrValido),
        .jr_alvo     (bus.JrAlvo),
        .prox_pc     (sel_pc),
        .halt        (halt),
        .fora        (fora)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado <= ST_RUN;
            pc     <= RESET_PC;
            cnt    <= '0;
        end else begin
            estado <= prox_estado;
            pc     <= prox_pc;
            cnt    <= prox_cnt;
        end
    end
    // halting and faulting instructions still retire, but leave the PC in place
    always_comb begin
        prox_estado = estado;
        prox_pc     = pc;
        prox_cnt    = cnt;
        if (estado == ST_RUN && !bus.Stall) begin
            prox_cnt    = (cnt == '1) ? cnt : cnt + 32'd1;
            prox_estado = halt ? ST_HALT : fora ? ST_FAULT : ST_RUN;
            prox_pc     = (halt || fora) ? pc : sel_pc;
        end
    end
    assign bus.Endereco   = pc;
    assign bus.PCMais1    = pc + 32'd1;
    assign bus.Halted     = estado == ST_HALT;
    assign bus.Fault      = estado == ST_FAULT;
    assign bus.InstrCount = cnt;
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: scoreboard bench walking the fetch unit through jump, branch, jr, stall, halt and fault
module tb_unidade_busca;
    import yousei_pkg::*;
    typedef struct packed {
        logic [31:0] pc;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } esperado_t;
    logic        Clock = 0;
    logic        Reset;
    logic [31:0] mem [0:52];
    esperado_t   fila [$];
    int          checks = 0;
    int          errors = 0;
    unidade_busca_if bus ();
    unidade_busca #(.RESET_PC(32'd0), .MEM_DEPTH(53)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus.master)
    );
    always #5 Clock = ~Clock;
    assign bus.Instrucao = (bus.Endereco < 32'd53) ? mem[bus.Endereco[5:0]] : {OP_NOP, 26'd0};
    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic reiniciar();
        Reset = 1;
        bus.Stall = 1;
        bus.BranchTaken = 0;
        bus.BranchAlvo = 0;
        bus.JrValido = 0;
        bus.JrAlvo = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 0;
        bus.Stall = 0;
        verifica("rst_endereco", bus.Endereco, 32'd0);
        verifica("rst_pcmais1", bus.PCMais1, 32'd1);
        verifica("rst_halted", {31'd0, bus.Halted}, 32'd0);
        verifica("rst_fault", {31'd0, bus.Fault}, 32'd0);
        verifica("rst_count", bus.InstrCount, 32'd0);
    endtask
    task automatic passo(input logic st, input logic br, input logic [15:0] balvo,
                         input logic jr, input logic [31:0] jalvo,
                         input logic [31:0] e_pc, input logic e_h, input logic e_f,
                         input logic [31:0] e_cnt);
        esperado_t e;
        bus.Stall = st;
        bus.BranchTaken = br;
        bus.BranchAlvo = balvo;
        bus.JrValido = jr;
        bus.JrAlvo = jalvo;
        fila.push_back('{pc: e_pc, halted: e_h, fault: e_f, cnt: e_cnt});
        @(posedge Clock);
        #1;
        e = fila.pop_front();
        verifica("endereco", bus.Endereco, e.pc);
        verifica("pcmais1", bus.PCMais1, e.pc + 32'd1);
        verifica("halted", {31'd0, bus.Halted}, {31'd0, e.halted});
        verifica("fault", {31'd0, bus.Fault}, {31'd0, e.fault});
        verifica("count", bus.InstrCount, e.cnt);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 53; i++) mem[i] = {OP_NOP, 26'd0};
        mem[2]  = {OP_JUMP, 26'd25};
        mem[3]  = {OP_JUMP, 26'd60};
        mem[12] = {OP_BEQ, 26'd21};
        mem[24] = {OP_JR, 26'd0};
        mem[52] = 32'h1400_0034;
        reiniciar();
        passo(0, 0, 0, 0, 0, 1, 0, 0, 1);
        passo(0, 0, 0, 0, 0, 2, 0, 0, 2);
        passo(0, 0, 0, 0, 0, 25, 0, 0, 3);
        passo(0, 1, 24, 0, 0, 24, 0, 0, 4);
        passo(0, 1, 10, 1, 35, 35, 0, 0, 5);
        passo(0, 1, 12, 0, 0, 12, 0, 0, 6);
        passo(0, 1, 21, 0, 0, 21, 0, 0, 7);
        passo(0, 1, 12, 0, 0, 12, 0, 0, 8);
        passo(0, 0, 0, 0, 0, 13, 0, 0, 9);
        passo(0, 1, 9, 0, 0, 9, 0, 0, 10);
        passo(1, 0, 0, 0, 0, 9, 0, 0, 10);
        passo(1, 1, 30, 0, 0, 9, 0, 0, 10);
        passo(1, 0, 0, 1, 40, 9, 0, 0, 10);
        passo(0, 0, 0, 0, 0, 10, 0, 0, 11);
        passo(0, 1, 52, 0, 0, 52, 0, 0, 12);
        passo(0, 0, 0, 0, 0, 52, 1, 0, 13);
        for (int i = 0; i < 10; i++) passo(0, 1, 5, 0, 0, 52, 1, 0, 13);
        reiniciar();
        passo(0, 0, 0, 1, 53, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) passo(0, 1, 2, 0, 0, 0, 0, 1, 1);
        reiniciar();
        passo(0, 0, 0, 0, 0, 1, 0, 0, 1);
        passo(0, 1, 3, 0, 0, 3, 0, 0, 2);
        passo(0, 0, 0, 0, 0, 3, 0, 1, 3);
        passo(0, 0, 0, 0, 0, 3, 0, 1, 3);
        passo(0, 1, 7, 1, 8, 3, 0, 1, 3);
        reiniciar();
        passo(0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 1, 1);
        verifica("scoreboard_empty", fila.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit for the Yousei single-cycle processor. Holds the program counter and drives the word address into the instruction memory. Selects the next PC from sequential, jump, branch and jr sources, and decodes jump and halt directly from the fetched word. Tracks run/halt/fault state and counts retired instructions.

## Interface

Parameters:
- RESET_PC, 0: PC value loaded on reset (word address).
- MEM_DEPTH, 53: number of valid instruction words. Addresses ≥ MEM_DEPTH are out of range.

Ports:
- Clock, in, 1: single clock; all state updates on its rising edge.
- Reset, in, 1: synchronous, active-high.
- Instrucao, in, 32: word returned by the instruction memory for Endereco, same cycle (combinational read).
- Stall, in, 1: hold PC and counter this cycle.
- BranchTaken, in, 1: beq resolved taken this cycle.
- BranchAlvo, in, 16: absolute branch target (instruction imm[15:0]), zero-extended.
- JrValido, in, 1: current instruction is jr.
- JrAlvo, in, 32: register value for jr.
- Endereco, out, 32: registered PC, to instruction memory.
- PCMais1, out, 32: Endereco+1, combinational, for link/debug.
- Halted, out, 1: core halted.
- Fault, out, 1: next PC was out of range.
- InstrCount, out, 32: retired-instruction counter.

## Operation

- Opcode is Instrucao[31:26]. The jump opcode is 6'b000101, with target Instrucao[25:0] zero-extended.
- Halt is a jump whose target equals Endereco. It is detected while in RUN and not stalled.
- States:
  - RUN: normal fetch.
  - HALT: PC frozen, Halted=1.
  - FAULT: PC frozen, Fault=1.
  - HALT and FAULT are left only by Reset.
- Next-PC priority in RUN, highest first:
  1. Stall: hold.
  2. JrValido: JrAlvo.
  3. BranchTaken: {16'b0, BranchAlvo}.
  4. Jump opcode: {6'b0, Instrucao[25:0]}.
  5. Otherwise: Endereco+1.
- Halt detection takes precedence over the jump update: the state goes to HALT and the PC is unchanged.
- Range check: if the selected next PC is ≥ MEM_DEPTH, the state goes to FAULT, the PC is not updated, and the counter still increments for the faulting instruction.
- JrValido and BranchTaken together is a decode error. jr wins; no flag is raised.
- InstrCount increments by 1 for each RUN cycle without Stall, including the halting instruction. It saturates at 32'hFFFF_FFFF.
- Arithmetic is unsigned 32-bit; PC+1 wraps modulo 2^32, but the range check catches the wrap first.

## Timing

- Reset values at the edge where Reset=1: Endereco=RESET_PC, state RUN, Halted=0, Fault=0, InstrCount=0. PCMais1 then reads RESET_PC+1.
- Reset mid-operation, in any state including HALT/FAULT, takes effect at that edge. Stall is ignored during Reset.
- Latency:
  - Instrucao is valid in the same cycle Endereco is presented.
  - The new PC appears one edge after the control inputs are sampled.
  - Halted and Fault assert one edge after the causing instruction.
- The instruction memory loads its contents on its first Clock edge. Hold Reset for ≥2 cycles after power-up.
- Stall, BranchTaken and JrValido are sampled only at the rising edge and must be stable in the cycle they apply to.

## Structure

- Shared package yousei_pkg holds:
  - opcode localparams: OP_JUMP=6'b000101, OP_BEQ=6'b001010, OP_JR=6'b010011, OP_NOP=6'b001100;
  - the state encoding (ST_RUN, ST_HALT, ST_FAULT);
  - the width constant WORD=32.
- One sub-module, selecao_prox_pc: combinational next-PC mux plus halt and range detection.
- The top level holds the PC register, the state register and the counter.

## Test plan

- Reset for 2 cycles, release, run program -> Endereco 0, 1, 2, then 25 (jump main at 2); InstrCount=3 on reaching 25.
- Word at 12 is beq with BranchTaken=1, BranchAlvo=21 -> next Endereco=21. With BranchTaken=0 -> 13.
- JrValido=1, JrAlvo=35 at address 24, with BranchTaken=1 forced simultaneously -> next Endereco=35 (jr wins).
- Fetch at 52 of the self-jump word 32'h1400_0034 -> Halted=1 next edge. Endereco stays 52 for ≥10 cycles. InstrCount stops. Reset returns Endereco to 0 and Halted to 0.
- Jump to 60 with MEM_DEPTH=53 -> Fault=1 next edge. Endereco holds the jump's address.
- Stall=1 for 3 cycles at address 9 -> Endereco=9 and InstrCount unchanged. Release -> 10 next edge.
